skew_feeder: RTL and testbench
==============================

Name: skew_feeder

Overview:
- Parametrised operand feeder for an N x N output-stationary systolic array multiplier.
- Holds matrices A and B in internal register files, loaded through a write port.
- On start, streams the diagonally skewed wavefronts onto 2N-1 A lanes and 2N-1 B lanes, then drives zeros for DRAIN cycles while the array drains.
- Handshake: start/busy/done, with an optional continuous-repeat mode.

Parameters:
- N, 3: matrix dimension. Lanes per operand = 2N-1. N >= 2.
- DW, 8: operand width in bits.
- DRAIN, 7: number of all-zero cycles after the last wavefront (3N-2 for N=3). DRAIN >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe into the operand store.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_addr  in  clog2(N*N)  row*N+col, zero-based.
- wr_data  in  DW  element value.
- wr_err  out  1  one-cycle pulse: write rejected because busy is high, or wr_addr >= N*N.
- start  in  1  begin a feed; sampled only when busy=0.
- cont  in  1  repeat mode; sampled at the end of each DRAIN phase.
- a_lanes  out  (2N-1)*DW  A lane j at [j*DW +: DW].
- b_lanes  out  (2N-1)*DW  B lane j at [j*DW +: DW].
- valid  out  1  high while a wavefront (FEED step) is on the lanes.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE; step counter = 0; a_lanes, b_lanes, valid, busy, done and wr_err = 0. The A/B store is NOT cleared; contents survive reset.
- Writes: accepted only when busy=0 and wr_addr < N*N. The store updates at the rising edge. A write and a start in the same cycle: the write lands first, and the run uses the new value.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE -> FEED when start=1 is sampled at edge t. All outputs are registered.
- FEED step k (0..N-1) appears on the lanes in cycle t+1+k, with valid=1 and busy=1:
  - a lane j = A[k][j-k] if 0 <= j-k < N, else 0.
  - b lane j = B[j-k][k] if 0 <= j-k < N, else 0.
  - This is row k of A and column k of B, shifted k lanes up.
- FEED -> DRAIN after step N-1. DRAIN holds DRAIN cycles with all lanes 0, valid=0, busy=1.
- End of DRAIN:
  - if cont=1, go straight to FEED step 0 with no idle gap; done pulses coincident with that step-0 cycle.
  - else go to DONE: done=1, busy=0, lanes 0 for one cycle, then IDLE.
- Run length: first wavefront at t+1; done at t+N+DRAIN+1.
- start while busy=1: ignored, no error flag. start held high in IDLE begins a new run each time IDLE is reached.
- The store is read live. It cannot change mid-run, because writes are rejected while busy.
- Reset asserted mid-run: lanes clear immediately; no done pulse.
- Counters: a single step counter sized clog2(max(N,DRAIN)+1), cleared on each phase change. No arithmetic on data; values pass through bit-exact.

Test Plan:
1. N=3, DW=8. Load A=1..9 and B=0x10..0x18 in row-major order, then pulse start at t. Required lane contents (lanes 0..4):
   - t+1: a={1,2,3,0,0}, b={10,13,16,0,0}
   - t+2: a={0,4,5,6,0}, b={0,11,14,17,0}
   - t+3: a={0,0,7,8,9}, b={0,0,12,15,18} (hex)
   - valid=1 for these three cycles; t+4..t+10 all zero; done=1 at t+11.
2. Write with wr_addr=9 in IDLE -> wr_err pulses; store unchanged; re-run gives scenario 1 output. Write during FEED -> wr_err pulses; lanes unchanged.
3. cont=1 throughout the first run -> second step-0 wavefront {1,2,3,0,0} at t+11 with done=1 that cycle; busy never drops.
4. rst=0 at t+2 -> all outputs 0 asynchronously. Release rst, start again -> scenario 1 values reproduced with no reload.
5. start re-pulsed at t+2 -> ignored; done still only at t+11.
6. N=4, DW=16, DRAIN=10, A=identity -> step k: a lane k+k=2k holds 1, all other A lanes 0; done at t+15.

Source files
------------

// File: rtl/skew_feeder.sv
// skew_feeder: operand feeder for an N x N output-stationary systolic array.
// Holds matrices A and B, then streams row k of A and column k of B, shifted
// k lanes up, onto 2N-1 lanes per operand, followed by DRAIN all-zero cycles.
module skew_feeder #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int DRAIN = 7,
  localparam int L    = 2 * N - 1,
  localparam int AW   = (N * N > 1) ? $clog2(N * N) : 1,
  localparam int CW   = $clog2(((N > DRAIN) ? N : DRAIN) + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_err,
  input  logic            start,
  input  logic            cont,
  output logic [L*DW-1:0] a_lanes,
  output logic [L*DW-1:0] b_lanes,
  output logic            valid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nstep;
  logic            addr_ok;
  logic            wr_ok;
  logic [DW-1:0]   a_mem  [N*N];
  logic [DW-1:0]   b_mem  [N*N];
  logic [DW-1:0]   a_view [N*N];
  logic [DW-1:0]   b_view [N*N];
  logic [L*DW-1:0] wave_a;
  logic [L*DW-1:0] wave_b;

  assign addr_ok = (int'(wr_addr) < N * N);
  assign wr_ok   = wr_en && !busy && addr_ok;

  // Operand store: written only while idle, read live by the wavefront logic.
  // NOTE: the store has no reset on purpose; contents survive rst and a plain
  // clocked memory maps onto RAM/flop arrays without reset fan-out.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else        a_mem[wr_addr] <= wr_data;
    end
  end

  // Store view with the current-cycle write forwarded, so a write issued
  // together with start is already visible in the first wavefront.
  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    a_view = a_mem;
    b_view = b_mem;
    if (wr_ok) begin
      if (wr_sel) b_view[wr_addr] = wr_data;
      else        a_view[wr_addr] = wr_data;
    end
  end

  // Index of the wavefront to be registered at the next edge.
  always_comb begin
    nstep = '0;
    if (state == S_FEED) nstep = cnt + CW'(1);
  end

  // Skewed wavefront for step nstep: lane j carries A[k][j-k] and B[j-k][k].
  always_comb begin
    int k;
    int d;
    wave_a = '0;
    wave_b = '0;
    k      = int'(nstep);
    d      = 0;
    for (int j = 0; j < L; j++) begin
      d = j - k;
      if (k < N && d >= 0 && d < N) begin
        wave_a[j*DW +: DW] = a_view[AW'(k * N + d)];
        wave_b[j*DW +: DW] = b_view[AW'(d * N + k)];
      end
    end
  end

  // Control FSM with registered lanes, handshake and write-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_lanes <= '0;
      b_lanes <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && (busy || !addr_ok);
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FEED;
            cnt     <= '0;
            a_lanes <= wave_a;
            b_lanes <= wave_b;
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FEED: begin
          if (cnt == CW'(N - 1)) begin
            state   <= S_DRAIN;
            cnt     <= '0;
            a_lanes <= '0;
            b_lanes <= '0;
            valid   <= 1'b0;
          end else begin
            cnt     <= cnt + CW'(1);
            a_lanes <= wave_a;
            b_lanes <= wave_b;
          end
        end
        S_DRAIN: begin
          if (cnt == CW'(DRAIN - 1)) begin
            cnt  <= '0;
            done <= 1'b1;
            if (cont) begin
              state   <= S_FEED;
              a_lanes <= wave_a;
              b_lanes <= wave_b;
              valid   <= 1'b1;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed checks of skew_feeder at N=3/DW=8 and N=4/DW=16.
module tb_skew_feeder;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int L  = 2 * N - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, wr_en, wr_sel, start, cont;
  logic [3:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_err, valid, busy, done;
  logic [L*DW-1:0] a_lanes, b_lanes;

  logic            wr_en4, wr_sel4, start4, cont4;
  logic [3:0]      wr_addr4;
  logic [15:0]     wr_data4;
  logic            wr_err4, valid4, busy4, done4;
  logic [111:0]    a_lanes4, b_lanes4;

  skew_feeder #(.N(3), .DW(8), .DRAIN(7)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .cont(cont),
    .a_lanes(a_lanes), .b_lanes(b_lanes), .valid(valid), .busy(busy), .done(done)
  );

  skew_feeder #(.N(4), .DW(16), .DRAIN(10)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_sel(wr_sel4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .wr_err(wr_err4), .start(start4), .cont(cont4),
    .a_lanes(a_lanes4), .b_lanes(b_lanes4), .valid(valid4), .busy(busy4), .done(done4)
  );

  int errors = 0;
  int checks = 0;
  logic [39:0] a_exp [3];
  logic [39:0] b_exp [3];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags are packed as {valid, busy, done}.
  task automatic check_step(input string tag, input int k, input logic [2:0] flags);
    check({tag, "_a"}, 128'(a_lanes), 128'(a_exp[k]));
    check({tag, "_b"}, 128'(b_lanes), 128'(b_exp[k]));
    check({tag, "_flags"}, 128'({valid, busy, done}), 128'(flags));
  endtask

  task automatic check_drain(input string tag);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check({tag, "_drain_lanes"}, 128'({a_lanes, b_lanes}), 128'(0));
      check({tag, "_drain_flags"}, 128'({valid, busy, done}), 128'(3'b010));
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done_lanes"}, 128'({a_lanes, b_lanes}), 128'(0));
    check({tag, "_done_flags"}, 128'({valid, busy, done}), 128'(3'b001));
    @(negedge clk);
    check({tag, "_idle_flags"}, 128'({valid, busy, done}), 128'(3'b000));
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[3:0];
    wr_data = data[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr4(input bit sel, input int addr, input int data);
    wr_en4   = 1'b1;
    wr_sel4  = sel;
    wr_addr4 = addr[3:0];
    wr_data4 = data[15:0];
    @(negedge clk);
    wr_en4 = 1'b0;
  endtask

  // Full N=3 run from IDLE; optionally re-pulses start during cycle t+2.
  task automatic full_run(input string tag, input bit repulse);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_step({tag, "_s0"}, 0, 3'b110);
    @(negedge clk);
    if (repulse) start = 1'b1;
    check_step({tag, "_s1"}, 1, 3'b110);
    @(negedge clk);
    start = 1'b0;
    check_step({tag, "_s2"}, 2, 3'b110);
    check_drain(tag);
    check_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;
    a_exp[0] = 40'h00_00_03_02_01;  b_exp[0] = 40'h00_00_16_13_10;
    a_exp[1] = 40'h00_06_05_04_00;  b_exp[1] = 40'h00_17_14_11_00;
    a_exp[2] = 40'h09_08_07_00_00;  b_exp[2] = 40'h18_15_12_00_00;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; cont = 1'b0;
    wr_en4 = 1'b0; wr_sel4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;
    start4 = 1'b0; cont4 = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("reset_lanes", 128'({a_lanes, b_lanes}), 128'(0));
    check("reset_flags", 128'({valid, busy, done, wr_err}), 128'(0));
    check("reset4_flags", 128'({valid4, busy4, done4, wr_err4}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: load A = 1..9, B = 0x10..0x18 and run.
    for (int i = 0; i < 9; i++) begin
      wr(1'b0, i, i + 1);
      wr(1'b1, i, 16 + i);
    end
    check("good_wr_no_err", 128'(wr_err), 128'(0));
    full_run("run1", 1'b0);

    // Scenario 2a: out-of-range write in IDLE flags and leaves store intact.
    wr(1'b0, 9, 8'hEE);
    check("oob_wr_err", 128'(wr_err), 128'(1));
    @(negedge clk);
    check("oob_wr_err_clear", 128'(wr_err), 128'(0));
    full_run("rerun", 1'b0);

    // Scenario 2b: write during FEED is rejected and lanes are unaffected.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_step("feedwr_s0", 0, 3'b110);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd4; wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    check("busy_wr_err", 128'(wr_err), 128'(1));
    check_step("feedwr_s1", 1, 3'b110);
    @(negedge clk);
    check_step("feedwr_s2", 2, 3'b110);
    check_drain("feedwr");
    check_done("feedwr");
    full_run("after_busy_wr", 1'b0);

    // Scenario 5: start re-pulsed while busy is ignored.
    full_run("repulse", 1'b1);

    // Write and start in the same cycle: the run sees the new value.
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h55; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("wr_start_a0", 128'(a_lanes), 128'(40'h00_00_03_02_55));
    repeat (11) @(negedge clk);
    check("wr_start_idle", 128'({valid, busy, done}), 128'(3'b000));
    wr(1'b0, 0, 1);

    // Scenario 3: continuous mode chains a second run with no idle gap.
    cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_step("cont_s0", 0, 3'b110);
    @(negedge clk);
    check_step("cont_s1", 1, 3'b110);
    @(negedge clk);
    check_step("cont_s2", 2, 3'b110);
    check_drain("cont");
    @(negedge clk);
    check_step("cont_r2_s0", 0, 3'b111);
    cont = 1'b0;
    @(negedge clk);
    check_step("cont_r2_s1", 1, 3'b110);
    @(negedge clk);
    check_step("cont_r2_s2", 2, 3'b110);
    check_drain("cont_r2");
    check_done("cont_r2");

    // Scenario 4: asynchronous reset mid-run, then rerun without reloading.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_step("rst_s0", 0, 3'b110);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_lanes", 128'({a_lanes, b_lanes}), 128'(0));
    check("async_rst_flags", 128'({valid, busy, done, wr_err}), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 128'({valid, busy, done}), 128'(3'b000));
    full_run("post_rst", 1'b0);

    // Scenario 6: N=4, DW=16, DRAIN=10 with identity A and B.
    for (int i = 0; i < 16; i++) begin
      wr4(1'b0, i, (i % 5 == 0) ? 1 : 0);
      wr4(1'b1, i, (i % 5 == 0) ? 1 : 0);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = 128'(1) << (32 * k);
      check("n4_a_step", 128'(a_lanes4), e);
      check("n4_b_step", 128'(b_lanes4), e);
      check("n4_step_flags", 128'({valid4, busy4, done4}), 128'(3'b110));
      @(negedge clk);
    end
    for (int c = 5; c < 15; c++) begin
      check("n4_drain_lanes", 128'({a_lanes4, b_lanes4}), 128'(0));
      check("n4_drain_flags", 128'({valid4, busy4, done4}), 128'(3'b010));
      @(negedge clk);
    end
    check("n4_done_flags", 128'({valid4, busy4, done4}), 128'(3'b001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
